pc_fetch_ctrl: RTL and testbench

//  Sequencer for the program counter of the 31-instruction MIPS core.

---
 rtl/pc_fetch_ctrl_if.sv | 31 +++
 rtl/pc_fetch_ctrl.sv | 97 +++++++++
 tb/tb_pc_fetch_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Bus bundle between the PC/fetch sequencer, instruction memory, decode and next-PC logic.
// The master side is the fetch controller; the slave side is everything around it.
`timescale 1ns/1ps
interface pc_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output inst_valid, inst, inst_pc,
    input  inst_ready,
    input  redirect_valid, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  inst_valid, inst, inst_pc,
    output inst_ready,
    output redirect_valid, redirect_target
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter owner and fetch sequencer: req/ack fetch from instruction memory,
// valid/ready hand-off to decode, and redirect handling that never leaks stale instructions.
`timescale 1ns/1ps
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ena,
  pc_fetch_ctrl_if.master bus,
  output logic [31:0]     pc_out
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_HOLD} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] pend, pend_n;
  logic [31:0] inst_q, inst_n;
  logic [31:0] inst_pc_q, inst_pc_n;
  logic [31:0] target;
  logic [31:0] pc_inc;
  state_t      after_run;

  assign target    = bus.redirect_target & 32'hFFFF_FFFC;
  assign pc_inc    = pc + 32'd4;
  assign after_run = ena ? S_FETCH : S_IDLE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      pend      <= 32'h0;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      pend      <= pend_n;
      inst_q    <= inst_n;
      inst_pc_q <= inst_pc_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    pend_n    = pend;
    inst_n    = inst_q;
    inst_pc_n = inst_pc_q;
    case (state)
      S_IDLE: begin
        if (bus.redirect_valid) pc_n = target;
        if (ena) state_n = S_FETCH;
      end
      S_FETCH: begin
        if (bus.imem_ack && !bus.redirect_valid) begin
          inst_n    = bus.imem_rdata;
          inst_pc_n = pc;
          pc_n      = pc_inc;
          state_n   = S_HOLD;
        end else if (bus.imem_ack) begin
          pc_n = target;
        end else if (bus.redirect_valid) begin
          pend_n  = target;
          state_n = S_DRAIN;
        end
      end
      // The address must stay put until the old handshake finishes, so the target waits in pend.
      S_DRAIN: begin
        if (bus.imem_ack) begin
          pc_n    = bus.redirect_valid ? target : pend;
          state_n = after_run;
        end else if (bus.redirect_valid) begin
          pend_n = target;
        end
      end
      S_HOLD: begin
        if (bus.redirect_valid) begin
          pc_n    = target;
          state_n = after_run;
        end else if (bus.inst_ready) begin
          state_n = after_run;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.imem_req   = (state == S_FETCH) || (state == S_DRAIN);
  assign bus.imem_addr  = pc;
  assign bus.inst_valid = (state == S_HOLD);
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign pc_out         = pc;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: behavioural memory responder plus a scoreboard of expected
// (inst_pc, inst) pairs pushed on completed fetches and popped on decode hand-offs.
`timescale 1ns/1ps
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ena;
  logic [31:0] pc_out;

  always #5 clk = ~clk;

  pc_fetch_ctrl_if bus();

  pc_fetch_ctrl #(.RESET_PC(32'h0040_0000)) dut (
    .clk    (clk),
    .reset  (reset),
    .ena    (ena),
    .bus    (bus),
    .pc_out (pc_out)
  );

  int          pass_count  = 0;
  int          check_count = 0;
  logic [63:0] sb[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];
  int          req_len[$];
  int          mem_wait;
  bit          mem_auto;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < req_log.size()) return req_log[i];
    return 32'hDEAD_DEAD;
  endfunction

  function automatic int count_pc(input logic [31:0] a);
    int n = 0;
    foreach (pop_log[i]) if (pop_log[i] == a) n++;
    return n;
  endfunction

  // Memory responder: acks after mem_wait idle request cycles, restarting per handshake.
  initial begin : mem_model
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (mem_auto) begin
        if (!reset || !bus.imem_req) begin
          bus.imem_ack = 1'b0;
          cnt = 0;
        end else begin
          if (bus.imem_ack) cnt = 0;
          if (cnt >= mem_wait) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = mem_word(bus.imem_addr);
          end else begin
            bus.imem_ack = 1'b0;
            cnt++;
          end
        end
      end
    end
  end

  // Mid-cycle monitor: tracks handshakes, kills fetches hit by a redirect, scores hand-offs.
  initial begin : monitor
    bit          killed, req_prev, ack_prev, push_prev, push_now;
    logic [31:0] addr_prev;
    logic [63:0] e;
    int          cur_len;
    killed = 0; req_prev = 0; ack_prev = 0; push_prev = 0; addr_prev = 0; cur_len = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        sb.delete();
        killed = 0; req_prev = 0; ack_prev = 0; push_prev = 0; cur_len = 0;
      end else begin
        if (push_prev) check_output("valid_after_ack", bus.inst_valid, 1);
        if (bus.imem_req && req_prev && !ack_prev) check_output("addr_stable", bus.imem_addr, addr_prev);
        if (bus.inst_valid) check_output("valid_has_entry", sb.size() != 0, 1);
        if (bus.inst_valid && bus.inst_ready && sb.size() != 0) begin
          e = sb.pop_front();
          check_output("inst_pc", bus.inst_pc, e[63:32]);
          check_output("inst", bus.inst, e[31:0]);
          pop_log.push_back(bus.inst_pc);
        end else if (bus.inst_valid && bus.redirect_valid && sb.size() != 0) begin
          e = sb.pop_front();
        end
        if (bus.imem_req && (!req_prev || ack_prev)) begin
          req_log.push_back(bus.imem_addr);
          cur_len = 0;
        end
        if (bus.imem_req) cur_len++;
        push_now = 0;
        if (bus.imem_req && bus.imem_ack) begin
          req_len.push_back(cur_len);
          if (!bus.redirect_valid && !killed) begin
            sb.push_back({bus.imem_addr, mem_word(bus.imem_addr)});
            push_now = 1;
          end
          killed = 0;
        end else if (bus.imem_req && bus.redirect_valid) begin
          killed = 1;
        end
        req_prev  = bus.imem_req;
        ack_prev  = bus.imem_ack;
        addr_prev = bus.imem_addr;
        push_prev = push_now;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation hung");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    req_log.delete();
    pop_log.delete();
    req_len.delete();
    reset = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [31:0] target);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = target;
    step(1);
    bus.redirect_valid  = 1'b0;
  endtask

  task automatic wait_req_addr(input logic [31:0] a, input bit need_ack, output bit found);
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.imem_req && bus.imem_addr == a && (!need_ack || bus.imem_ack)) begin
        found = 1;
        break;
      end
      step(1);
    end
  endtask

  initial begin : main
    bit          found;
    logic [31:0] held_inst, held_pc;
    reset = 1'b0; ena = 1'b0; mem_auto = 1'b1; mem_wait = 0;
    bus.inst_ready = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_target = 32'h0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
    step(2);
    check_output("rst_req", bus.imem_req, 0);
    check_output("rst_addr", bus.imem_addr, 32'h0040_0000);
    check_output("rst_valid", bus.inst_valid, 0);
    check_output("rst_inst", bus.inst, 0);
    check_output("rst_inst_pc", bus.inst_pc, 0);
    check_output("rst_pc", pc_out, 32'h0040_0000);

    // Zero-wait sequential fetch
    reset = 1'b1; ena = 1'b1;
    step(12);
    check_output("t1_addr0", log_at(0), 32'h0040_0000);
    check_output("t1_addr1", log_at(1), 32'h0040_0004);
    check_output("t1_addr2", log_at(2), 32'h0040_0008);
    check_output("t1_len0", req_len.size() != 0 ? req_len[0] : -1, 1);

    // Three wait cycles
    ena = 1'b0; mem_wait = 3;
    do_reset();
    ena = 1'b1;
    step(10);
    check_output("t2_addr0", log_at(0), 32'h0040_0000);
    check_output("t2_len0", req_len.size() != 0 ? req_len[0] : -1, 4);

    // Redirect while a slow fetch is outstanding
    ena = 1'b0; mem_wait = 3;
    do_reset();
    ena = 1'b1;
    wait_req_addr(32'h0040_0004, 0, found);
    check_output("t3_found", found, 1);
    step(1);
    apply_stimulus(32'h0040_0100);
    step(15);
    check_output("t3_addr2", log_at(2), 32'h0040_0100);
    check_output("t3_no_stale", count_pc(32'h0040_0004), 0);
    check_output("t3_new_seen", count_pc(32'h0040_0100), 1);

    // Redirect coinciding with ack
    ena = 1'b0; mem_wait = 2;
    do_reset();
    ena = 1'b1;
    wait_req_addr(32'h0040_0004, 1, found);
    check_output("t4_found", found, 1);
    apply_stimulus(32'h0040_0200);
    step(12);
    check_output("t4_addr2", log_at(2), 32'h0040_0200);
    check_output("t4_no_stale", count_pc(32'h0040_0004), 0);

    // Decode back-pressure in S_HOLD
    ena = 1'b0; mem_wait = 0; bus.inst_ready = 1'b0;
    do_reset();
    ena = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.inst_valid) found = 1;
      else step(1);
    end
    check_output("t5_found", found, 1);
    check_output("t5_inst_pc", bus.inst_pc, 32'h0040_0000);
    check_output("t5_inst", bus.inst, mem_word(32'h0040_0000));
    held_inst = bus.inst;
    held_pc   = bus.inst_pc;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check_output("t5_hold_inst", bus.inst, held_inst);
      check_output("t5_hold_pc", bus.inst_pc, held_pc);
      check_output("t5_hold_req", bus.imem_req, 0);
      check_output("t5_hold_valid", bus.inst_valid, 1);
    end
    bus.inst_ready = 1'b1;
    step(4);
    check_output("t5_next_addr", log_at(1), 32'h0040_0004);

    // Address wrap after a misaligned redirect
    ena = 1'b0; mem_wait = 0;
    do_reset();
    step(1);
    apply_stimulus(32'hFFFF_FFFF);
    check_output("t6_pc_masked", pc_out, 32'hFFFF_FFFC);
    ena = 1'b1;
    step(8);
    check_output("t6_addr0", log_at(0), 32'hFFFF_FFFC);
    check_output("t6_addr1", log_at(1), 32'h0000_0000);
    check_output("t6_top_seen", count_pc(32'hFFFF_FFFC), 1);

    // Reset in the middle of a fetch, then a stray ack
    mem_wait = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.imem_req && !bus.imem_ack) found = 1;
      else step(1);
    end
    check_output("t6_midfetch", found, 1);
    reset = 1'b0;
    #1;
    check_output("t6_rst_req", bus.imem_req, 0);
    check_output("t6_rst_addr", bus.imem_addr, 32'h0040_0000);
    check_output("t6_rst_valid", bus.inst_valid, 0);
    check_output("t6_rst_inst", bus.inst, 0);
    check_output("t6_rst_inst_pc", bus.inst_pc, 0);
    mem_auto = 1'b0; ena = 1'b0;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
    step(1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_output("t6_stray_req", bus.imem_req, 0);
      check_output("t6_stray_valid", bus.inst_valid, 0);
      check_output("t6_stray_pc", pc_out, 32'h0040_0000);
    end
    bus.imem_ack = 1'b0;
    mem_auto = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
